// File: rtl/sequence_gen.sv
// sequence_gen: serial pattern transmitter, MSB first, with repeats and idle gaps between copies
module sequence_gen #(
  parameter int               PAT_W    = 8,
  parameter logic [PAT_W-1:0] PAT_DEF  = 8'b0111_0001,
  parameter int               CNT_W    = 4,
  parameter int               GAP_CYC  = 0,
  parameter logic             IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] rep,
  input  logic             abort,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);
  localparam int GW = $clog2(GAP_CYC + 2);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state, state_d;
  logic [PAT_W-1:0] pat, pat_d, shreg, shreg_d;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic accept, last_bit;
  assign accept   = start && !abort && (state == IDLE || state == DONE);
  assign last_bit = bit_cnt == BW'(PAT_W - 1);
  // next state and counters; abort blocks a start in the same cycle
  always_comb begin
    state_d   = state;
    pat_d     = pat;
    shreg_d   = shreg;
    rep_cnt_d = rep_cnt;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    if (accept) begin
      state_d   = SEND;
      pat_d     = use_def ? PAT_DEF : pattern_in;
      shreg_d   = pat_d;
      rep_cnt_d = rep;
      bit_cnt_d = '0;
    end else if (state == DONE) begin
      state_d = IDLE;
    end else if ((state == SEND || state == GAP) && abort) begin
      state_d   = IDLE;
      rep_cnt_d = '0;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end else if (state == SEND && !last_bit) begin
      shreg_d   = shreg << 1;
      bit_cnt_d = bit_cnt + 1'b1;
    end else if (state == SEND && rep_cnt == '0) begin
      state_d   = DONE;
      bit_cnt_d = '0;
    end else if (state == SEND) begin
      state_d   = GAP_CYC == 0 ? SEND : GAP;
      rep_cnt_d = rep_cnt - 1'b1;
      shreg_d   = pat;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end else if (state == GAP) begin
      state_d   = gap_cnt == GW'(GAP_CYC - 1) ? SEND : GAP;
      gap_cnt_d = gap_cnt + 1'b1;
    end
  end
  // state register; outputs registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat     <= '0;
      shreg   <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      a       <= IDLE_BIT;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      pat     <= pat_d;
      shreg   <= shreg_d;
      rep_cnt <= rep_cnt_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      a       <= state_d == SEND ? shreg_d[PAT_W-1] : IDLE_BIT;
      a_valid <= state_d == SEND;
      busy    <= state_d == SEND || state_d == GAP;
      done    <= state_d == DONE;
    end
  end
endmodule

// File: doc/sequence_gen.md
# sequence_gen

Serial pattern transmitter: on a start request it latches a PAT_W-bit pattern and shifts it out MSB first, one bit per clock, on the single-bit line `a`, optionally repeating it with idle gaps between copies. It drives the `a` input of the serial sequence detectors in the same design. Its default pattern 8'b0111_0001 is the sequence those detectors match, so the block also serves as the stimulus source for them.

## Interface
- PAT_W, 8, pattern length in bits (≥2)
- PAT_DEF, 8'b0111_0001, pattern sent when `use_def`=1
- CNT_W, 4, width of repeat count
- GAP_CYC, 0, idle cycles inserted between consecutive copies (0 = back-to-back)
- IDLE_BIT, 1'b1, level of `a` when not transmitting
- One clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only when `busy`=0
- use_def  in  1  sampled with accepted start: 1 = send PAT_DEF, 0 = send pattern_in
- pattern_in  in  PAT_W  pattern, sampled with accepted start
- rep  in  CNT_W  sampled with accepted start; copies sent = rep+1
- abort  in  1  stop transmission, return to IDLE
- a  out  1  serial data, registered
- a_valid  out  1  1 while `a` carries a pattern bit
- busy  out  1  transmission in progress
- done  out  1  one-cycle pulse after the final bit of the final copy

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: `a`=IDLE_BIT, a_valid=0, busy=0.
  - start=1 latches shift register (pattern), rep_cnt=rep, bit_cnt=0 → SEND.
- SEND: `a`=shreg[PAT_W-1], a_valid=1, busy=1. Shift left each cycle; bit_cnt increments.
  - After bit PAT_W-1, if rep_cnt=0 → DONE.
  - Else rep_cnt decrements, shift register reloads the latched pattern, bit_cnt=0, then:
    - GAP_CYC=0 → stay in SEND (next bit is the new copy's MSB);
    - otherwise → GAP.
- GAP: `a`=IDLE_BIT, a_valid=0, busy=1 for exactly GAP_CYC cycles → SEND.
- DONE: one cycle; done=1, busy=0, `a`=IDLE_BIT, a_valid=0.
  - start=1 in this cycle is accepted (same as IDLE).
  - Otherwise → IDLE.
- start while busy=1 is ignored. The latched pattern, rep and use_def are unaffected by input changes during transmission.
- abort=1 in SEND or GAP: next cycle is IDLE with idle outputs; no done pulse. Abort in IDLE or DONE has no effect. Abort has priority over start in the same cycle.
- rst=1 at any time, including mid-transmission: next cycle state=IDLE, `a`=IDLE_BIT, a_valid=0, busy=0, done=0, all counters 0. No done pulse.
- Counters:
  - bit_cnt is $clog2(PAT_W) bits and wraps at PAT_W-1, not at a power of 2.
  - rep_cnt is CNT_W bits, so the maximum is 2^CNT_W copies (rep all-ones).

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start accepted at edge k:
  - bit i of copy 0 is on `a` in cycle k+1+i, with a_valid=1.
  - busy=1 from cycle k+1.
- Copy j (0-based) begins in cycle k+1+j·(PAT_W+GAP_CYC).
- done is high in cycle k+1+(rep+1)·PAT_W+rep·GAP_CYC, with busy=0 in that cycle.
- Minimum start-to-start spacing: the accepting edge of the next start is the edge ending the done cycle. There are no dead cycles between transmissions.
- Downstream registered-shift detector (8-bit window, registered match): match is high 2 cycles after the cycle carrying the last pattern bit.

## Test plan
- Reset, then default pattern: use_def=1, rep=0, GAP_CYC=0, start at edge k.
  - `a`=0,1,1,1,0,0,0,1 in cycles k+1..k+8; done in k+9.
  - Connected detector (rst_n=~rst) shows match=1 only in cycle k+10.
- Repeat back-to-back: pattern_in=8'hA5, use_def=0, rep=2, GAP_CYC=0.
  - 24 contiguous bits 10100101×3 in k+1..k+24, a_valid held 1; done in k+25.
- Gap insertion with GAP_CYC=3, rep=1, default pattern:
  - bits in k+1..k+8;
  - a=1, a_valid=0, busy=1 in k+9..k+11;
  - bits in k+12..k+19; done in k+20.
- Start handling: start held high throughout, rep=0.
  - Second transmission's first bit appears in the cycle after done; no extra pulses.
  - Changing pattern_in mid-send does not alter the output bits.
- Abort at cycle k+4 of a rep=3 transmission:
  - cycle k+5 is idle (a=1, busy=0); done never asserts.
  - Abort and start in the same IDLE cycle → remains IDLE.
- rst=1 for one cycle at k+3:
  - all outputs at reset values next cycle; no done.
  - A new start then transmits correctly from bit 0.
